hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Produces the EX-stage forwarding selects ForwardAE/ForwardBE.
- Detects load-use hazards and issues stall/flush on taken branches/jumps.
- Sequences a multi-cycle EX unit (mul/div) through a start/done handshake and freezes the front of the pipeline while that unit is busy.

Parameters:
- REG_AW, 5, register address width.
- MC_TIMEOUT, 64, maximum cycles in BUSY before the watchdog aborts; legal range 2..255.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- Rs1D, Rs2D  in  REG_AW  source regs of the D-stage instruction.
- Rs1E, Rs2E  in  REG_AW  source regs of the E-stage instruction.
- RdE  in  REG_AW  destination of the E-stage instruction.
- ResultSrcE0  in  1  E-stage instruction is a load.
- RdM  in  REG_AW  destination in M.
- RegWriteM  in  1  M writes the register file.
- RdW  in  REG_AW  destination in W.
- RegWriteW  in  1  W writes the register file.
- PCSrcE  in  1  taken branch/jump resolved in E.
- McReqE  in  1  E-stage instruction needs the multi-cycle unit.
- McDoneE  in  1  multi-cycle result valid (single-cycle pulse).
- ForwardAE, ForwardBE  out  2  forwarding select: 00=RF, 10=ALU_ResultM, 01=ResultW.
- StallF, StallD, StallE  out  1  hold the stage register.
- FlushD, FlushE, FlushM  out  1  insert a bubble into the stage register.
- McStartE  out  1  start pulse to the multi-cycle unit.
- McBusy  out  1  FSM is in BUSY.
- McTimeout  out  1  sticky watchdog flag.

Behaviour:
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else ForwardAE=00.
  - ForwardBE uses the same rules with Rs2E.
  - M has priority over W. x0 is never forwarded.
- Load-use:
  - lwStall = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - Asserts StallF, StallD, FlushE for exactly the cycles it holds, which is 1 cycle in normal flow.
- Branch: PCSrcE asserts FlushD and FlushE in the same cycle. A flush of a stage overrides a stall of that stage.
- FSM states and transitions:
  - IDLE -> BUSY when McReqE=1. McStartE=1 for that one cycle, combinational in IDLE.
  - BUSY -> IDLE when McDoneE=1.
  - BUSY -> IDLE when the cycle counter reaches MC_TIMEOUT. This sets McTimeout; the instruction is then released as if done.
  - McDoneE is ignored in IDLE.
- mcStall = (IDLE && McReqE) || (BUSY && !McDoneE && !timeout_hit).
  - mcStall asserts StallF, StallD, StallE, FlushM.
  - On the McDoneE cycle all stalls drop, so the instruction leaves E at the next edge. Minimum unit latency is 1 cycle; done in the start cycle is illegal.
- Cycle counter: 8-bit. Cleared on IDLE->BUSY, increments each BUSY cycle, saturates (no wrap).
- Simultaneous events:
  - mcStall and lwStall are mutually exclusive by construction (a single E instruction).
  - If both appear, mcStall wins and FlushE is suppressed so E is held, not bubbled.
  - PCSrcE with McReqE cannot occur; if it does, the flush wins and no start is issued.
- McBusy is registered and equals state==BUSY.
- Reset values with rst=0 (applies immediately, including mid-BUSY):
  - state=IDLE, counter=0, McTimeout=0.
  - McStartE=0, McBusy=0.
  - All stalls 0; FlushD=FlushE=FlushM=1.
  - ForwardAE=ForwardBE=00.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
  - Defined: adds outputs StallCycles[31:0] and FlushCycles[31:0], reset to 0.
  - StallCycles increments on any cycle with StallF=1.
  - FlushCycles increments on any cycle with FlushE=1.
  - Both counters wrap at 2^32.
  - Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. With RdM=0 -> ForwardAE=01.
- Load in E with RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1 for 1 cycle. Next cycle ForwardBE=01 from W; final x3 value correct.
- PCSrcE=1 for one cycle -> FlushD=FlushE=1 that cycle only; StallF=0.
- McReqE=1, McDoneE after 4 cycles -> McStartE high for 1 cycle. StallF/D/E and FlushM high for 4 cycles, low on the done cycle; McBusy high for 4 cycles.
- McReqE=1, McDoneE never asserted, MC_TIMEOUT=8 -> return to IDLE after 8 BUSY cycles; McTimeout=1 and remains 1 until rst.
- rst pulled low mid-BUSY -> McBusy=0 and stalls=0 immediately. After release, McReqE restarts with a fresh McStartE pulse. With HAZARD_PERF_CNT_EN defined, counters read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage F/D/E/M/W pipeline.
// Latency: forwarding selects, stalls and flushes are combinational from the
//   current inputs and FSM state; McBusy/McTimeout are registered.
// Backpressure: freezes F/D (load-use) or F/D/E (multi-cycle unit busy);
//   a flush of a stage always overrides a stall of that stage.
//
// Ports:
//   clk, rst (async, active-low)
//   Rs1D/Rs2D, Rs1E/Rs2E, RdE, ResultSrcE0, RdM/RegWriteM, RdW/RegWriteW : hazard inputs
//   PCSrcE : taken branch/jump in E; McReqE/McDoneE : multi-cycle unit handshake
//   ForwardAE/ForwardBE : 00=RF, 10=ALU_ResultM, 01=ResultW
//   StallF/D/E, FlushD/E/M : pipeline register controls
//   McStartE, McBusy, McTimeout : multi-cycle unit start / busy / sticky watchdog
// Optional macro HAZARD_PERF_CNT_EN adds StallCycles/FlushCycles counters.
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int MC_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              ResultSrcE0,
    input  logic [REG_AW-1:0] RdM,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    input  logic              McReqE,
    input  logic              McDoneE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              McStartE,
    output logic              McBusy,
    output logic              McTimeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       StallCycles,
    output logic [31:0]       FlushCycles
`endif
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [8:0] TIMEOUT_LIM = 9'(MC_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       to_q, to_d;

    logic       mc_start, mc_stall, timeout_hit;
    logic       lw_stall, lw_eff;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;

    // Forwarding: M has priority over W, x0 never forwarded.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      fwd_a = 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) fwd_a = 2'b01;
        if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      fwd_b = 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) fwd_b = 2'b01;
    end

    // Multi-cycle unit sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        mc_start    = 1'b0;
        mc_stall    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A simultaneous branch flush kills the request: no start.
                if (McReqE && !PCSrcE) begin
                    state_d  = S_BUSY;
                    cnt_d    = 8'd0;
                    mc_start = 1'b1;
                    mc_stall = 1'b1;
                end
            end
            S_BUSY: begin
                // cnt_q counts completed BUSY cycles; this cycle is number cnt_q+1.
                timeout_hit = (({1'b0, cnt_q} + 9'd1) == TIMEOUT_LIM);
                cnt_d       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                if (McDoneE) begin
                    state_d = S_IDLE;
                end else if (timeout_hit) begin
                    // Release the instruction as if done and remember the abort.
                    state_d = S_IDLE;
                    to_d    = 1'b1;
                end else begin
                    mc_stall = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    // Stall/flush combination. A multi-cycle stall holds E, so it masks the
    // load-use bubble into E.
    always_comb begin
        lw_stall = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
        lw_eff   = lw_stall && !mc_stall;
        flush_d  = PCSrcE;
        flush_e  = PCSrcE || lw_eff;
        flush_m  = mc_stall;
        stall_f  = lw_eff || mc_stall;
        stall_d  = stall_f && !flush_d;
        stall_e  = mc_stall && !flush_e;
    end

    // Reset forces the pipeline into a safe state immediately: no stalls,
    // all stage registers bubbled, no forwarding, no start pulse.
    assign ForwardAE = rst ? fwd_a : 2'b00;
    assign ForwardBE = rst ? fwd_b : 2'b00;
    assign StallF    = rst & stall_f;
    assign StallD    = rst & stall_d;
    assign StallE    = rst & stall_e;
    assign FlushD    = !rst | flush_d;
    assign FlushE    = !rst | flush_e;
    assign FlushM    = !rst | flush_m;
    assign McStartE  = rst & mc_start;
    assign McBusy    = (state_q == S_BUSY);
    assign McTimeout = to_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (StallF) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (FlushE) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign StallCycles = stall_cnt_q;
    assign FlushCycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, McReqE, McDoneE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic       McStartE, McBusy, McTimeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCycles, FlushCycles;
`endif

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.REG_AW(5), .MC_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE0(ResultSrcE0), .RdM(RdM), .RegWriteM(RegWriteM),
        .RdW(RdW), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .McReqE(McReqE), .McDoneE(McDoneE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .McStartE(McStartE), .McBusy(McBusy), .McTimeout(McTimeout)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCycles(StallCycles), .FlushCycles(FlushCycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compact check of the six stall/flush controls: {StallF,StallD,StallE,FlushD,FlushE,FlushM}
    task automatic chk_ctl(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, StallF, StallD, StallE, FlushD, FlushE, FlushM}, {26'd0, exp});
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; McReqE = 0; McDoneE = 0;

        // Reset: even with forwarding/stall-inducing inputs, outputs are forced.
        RdM = 5'd5; RegWriteM = 1; Rs1E = 5'd5; ResultSrcE0 = 1; RdE = 5'd3; Rs1D = 5'd3; McReqE = 1;
        #2;
        chk("rst_fwdA", ForwardAE, 2'b00);
        chk_ctl("rst_ctl", 6'b000111);
        chk("rst_start", McStartE, 1'b0);
        chk("rst_busy", McBusy, 1'b0);
        chk("rst_to", McTimeout, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_stallcnt", StallCycles, 32'd0);
        chk("rst_flushcnt", FlushCycles, 32'd0);
`endif
        next_cycle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0; McReqE = 0;
        rst = 1'b1;
        #1;
        chk_ctl("idle_ctl", 6'b000000);

        // Forwarding: M beats W, x0 not forwarded.
        next_cycle();
        RdM = 5'd5; RegWriteM = 1; RdW = 5'd5; RegWriteW = 1; Rs1E = 5'd5; Rs2E = 5'd0;
        #1;
        chk("fwd_m_prio", ForwardAE, 2'b10);
        chk("fwd_x0", ForwardBE, 2'b00);
        RdM = 5'd0;
        #1;
        chk("fwd_w", ForwardAE, 2'b01);
        RdM = 5'd7; Rs2E = 5'd7; RegWriteM = 0;
        #1;
        chk("fwd_nowrite", ForwardBE, 2'b00);
        RegWriteM = 1;
        #1;
        chk("fwd_b_m", ForwardBE, 2'b10);

        // Load-use: load x3 in E, consumer reads x3 in D.
        next_cycle();
        RdM = 0; RegWriteM = 0; RdW = 0; RegWriteW = 0; Rs1E = 0; Rs2E = 0;
        ResultSrcE0 = 1; RdE = 5'd3; Rs2D = 5'd3;
        #1;
        chk_ctl("lw_stall", 6'b110010);
        // Bubble now in E, load in M.
        next_cycle();
        ResultSrcE0 = 0; RdE = 0; RdM = 5'd3; RegWriteM = 1;
        #1;
        chk_ctl("lw_release", 6'b000000);
        // Consumer in E, load result in W.
        next_cycle();
        RdM = 0; RegWriteM = 0; RdW = 5'd3; RegWriteW = 1; Rs2E = 5'd3; Rs2D = 0;
        #1;
        chk("lw_fwd_w", ForwardBE, 2'b01);
        // Load to x0 never stalls.
        next_cycle();
        RdW = 0; RegWriteW = 0; Rs2E = 0;
        ResultSrcE0 = 1; RdE = 5'd0; Rs1D = 5'd0;
        #1;
        chk_ctl("lw_x0", 6'b000000);

        // Taken branch flushes D and E for that cycle only.
        next_cycle();
        ResultSrcE0 = 0; PCSrcE = 1;
        #1;
        chk_ctl("br_flush", 6'b000110);
        next_cycle();
        PCSrcE = 0;
        #1;
        chk_ctl("br_after", 6'b000000);

        // McDoneE in IDLE is ignored.
        next_cycle();
        McDoneE = 1;
        #1;
        chk_ctl("done_idle", 6'b000000);
        next_cycle();
        McDoneE = 0;
        #1;
        chk("done_idle_busy", McBusy, 1'b0);

        // Multi-cycle op, done in the 4th cycle after start.
        next_cycle();
        McReqE = 1;
        #1;
        chk("mc_start", McStartE, 1'b1);
        chk("mc_busy0", McBusy, 1'b0);
        chk_ctl("mc_ctl0", 6'b111001);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            #1;
            chk("mc_start_low", McStartE, 1'b0);
            chk("mc_busy", McBusy, 1'b1);
            chk_ctl("mc_ctl", 6'b111001);
        end
        next_cycle();
        McDoneE = 1;
        #1;
        chk_ctl("mc_done_ctl", 6'b000000);
        chk("mc_done_busy", McBusy, 1'b1);
        next_cycle();
        McDoneE = 0; McReqE = 0;
        #1;
        chk("mc_idle_busy", McBusy, 1'b0);
        chk("mc_no_to", McTimeout, 1'b0);

        // Watchdog: no done, MC_TIMEOUT=8 BUSY cycles.
        next_cycle();
        McReqE = 1;
        #1;
        chk("to_start", McStartE, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            next_cycle();
            #1;
            chk_ctl("to_stall", 6'b111001);
            chk("to_busy", McBusy, 1'b1);
        end
        next_cycle();
        #1;
        chk_ctl("to_release", 6'b000000);
        chk("to_busy8", McBusy, 1'b1);
        chk("to_flag_pre", McTimeout, 1'b0);
        next_cycle();
        McReqE = 0;
        #1;
        chk("to_idle", McBusy, 1'b0);
        chk("to_flag", McTimeout, 1'b1);
        next_cycle();
        next_cycle();
        #1;
        chk("to_sticky", McTimeout, 1'b1);

        // Asynchronous reset in the middle of BUSY.
        next_cycle();
        McReqE = 1;
        next_cycle();
        next_cycle();
        #1;
        chk("rb_busy", McBusy, 1'b1);
        rst = 0;
        #1;
        chk("rb_busy_clr", McBusy, 1'b0);
        chk_ctl("rb_ctl", 6'b000111);
        chk("rb_to_clr", McTimeout, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        chk("rb_stallcnt", StallCycles, 32'd0);
        chk("rb_flushcnt", FlushCycles, 32'd0);
`endif
        next_cycle();
        rst = 1;
        #1;
        chk("rb_restart", McStartE, 1'b1);
        chk_ctl("rb_restart_ctl", 6'b111001);

        // Branch coinciding with a request: flush wins, no start.
        next_cycle();
        McReqE = 0;
        rst = 0;
        #1;
        rst = 1;
        #1;
        McReqE = 1; PCSrcE = 1;
        #1;
        chk("br_mc_nostart", McStartE, 1'b0);
        chk_ctl("br_mc_ctl", 6'b000110);
        next_cycle();
        McReqE = 0; PCSrcE = 0;
        #1;
        chk("br_mc_idle", McBusy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
